t5_wbck: RTL and testbench
==========================

// Module: t5_wbck
// PURPOSE
//  Register-file writeback stage for the 4-hart barrel core. It is the writer
//  side of the t5_gprf write port (mwre/mhart/rd0a/rd0d). It merges two
//  result sources: execute results, which arrive unstalled each cycle, and
//  load returns, which use a valid/ready handshake and are buffered in a FIFO.
//  It also reports per-hart pending loads so decode can interlock.
// PARAMETERS
//  XLEN   32  data width; must match t5_gprf
//  DEPTH  2   load FIFO entries; power of 2, >=2
//  STARVE 4   cycles a load FIFO head may wait before execute is stalled; >=1
// PORTS
//  sclk    in   1     clock; all state updates on rising edge
//  rstn    in   1     asynchronous active-low reset
//  xwre    in   1     execute result valid
//  xhart   in   2     execute result hart id
//  xrda    in   5     execute destination register
//  xrdd    in   XLEN  execute result data
//  xstall  out  1     stall request to execute; registered
//  lvld    in   1     load return valid
//  lrdy    out  1     load return ready = FIFO not full; combinational from state
//  lhart   in   2     load hart id
//  lrda    in   5     load destination register
//  lrdd    in   XLEN  load data
//  lpend   out  4     bit h=1: a load for hart h is queued or in the output reg
//  mwre    out  1     regfile write enable; registered
//  mhart   out  2     regfile write hart; registered
//  rd0a    out  5     regfile write address; registered
//  rd0d    out  XLEN  regfile write data; registered
// BEHAVIOUR
//  Reset (rstn=0, async): mwre=0, mhart=0, rd0a=0, rd0d=0, xstall=0, lpend=0.
//   FIFO is emptied (lrdy=1 once rstn deasserts) and the wait counter is 0.
//   A reset mid-operation silently discards queued loads.
//  Load accept: lvld&lrdy at edge t enqueues the load. A load with lrda==0 is
//   accepted and discarded; it never enters the FIFO.
//  Port selection, evaluated every edge, first matching rule wins:
//   1 xstall==1 and FIFO not empty: pop the head and write it.
//   2 xwre==1 and xrda!=0: write the execute result.
//   3 FIFO not empty: pop the head and write it.
//   4 otherwise: mwre<=0; other outputs hold their last value.
//   An execute result with xrda==0 is dropped and frees the port for rule 3.
//  Latency: an execute result sampled at edge t appears on mwre/rd0* after
//   edge t. A load accepted at edge t is written at edge t+1 at the earliest.
//  Simultaneous push and pop: a pop happens in the same edge as a push, so a
//   full FIFO is not bypassed. lrdy depends only on the occupancy before the
//   edge.
//  Starvation counter wcnt:
//   - cleared when the FIFO is empty or the head pops;
//   - otherwise incremented each edge, saturating at STARVE.
//   - xstall<=1 on the edge where wcnt reaches STARVE; xstall<=0 otherwise.
//   - xstall is high for exactly one cycle per starvation event.
//  Execute must hold xwre=0 while xstall=1. If xwre=1 in that cycle, the
//   execute result is discarded; this is a protocol error that the bench
//   flags.
//  lpend[h] = OR over valid FIFO entries with hart==h, plus
//   (mwre & the output reg was loaded from the FIFO & mhart==h).
//  FIFO pointers: log2(DEPTH)+1 bits; wrap modulo 2*DEPTH.
//   full  = pointer MSBs differ and the low bits are equal.
//   empty = pointers equal.
// TESTING
//  1 Reset: rstn low mid-stream with 2 queued loads -> all outputs 0,
//    lpend=0, lrdy=1; no writes after release.
//  2 ALU path: xwre=1, xhart=2, xrda=5, xrdd=0xDEADBEEF -> next cycle
//    mwre=1, mhart=2, rd0a=5, rd0d=0xDEADBEEF. xrda=0 -> mwre=0.
//  3 Load merge: load hart1 r7=0x11 with xwre=0 -> written 1 cycle later;
//    lpend[1] high from accept until the write cycle, then clears.
//  4 Backpressure: xwre=1 every cycle, 3 loads offered -> lrdy=0 after 2
//    accepts, third held. xstall=1 for exactly one cycle after STARVE=4
//    waits; head written that cycle; order of writes matches accept order.
//  5 x0 load: lvld, lrda=0 -> accepted, no write, lpend unchanged, FIFO
//    occupancy unchanged.
//  6 Wrap: 10 back-to-back loads with no ALU traffic -> all 10 written in
//    order, data intact across pointer wrap, lrdy never drops.

Source files
------------

// File: rtl/t5_wbck.sv
// rtl/t5_wbck.sv - register-file writeback stage merging execute results and buffered load returns
//
// Purpose: drives the t5_gprf write port (mwre/mhart/rd0a/rd0d) from two sources:
//   execute results (unstalled, one per cycle) and load returns (valid/ready,
//   buffered in a DEPTH-entry FIFO). A starving FIFO head stalls execute for one
//   cycle so the head can drain. lpend reports per-hart loads in flight.
// Ports:
//   sclk, rstn                  clock, asynchronous active-low reset
//   xwre, xhart, xrda, xrdd     execute result (valid, hart, dest reg, data)
//   xstall                      one-cycle stall request to execute (registered)
//   lvld, lrdy                  load return handshake (lrdy = FIFO not full)
//   lhart, lrda, lrdd           load return hart, dest reg, data
//   lpend                       per-hart pending-load flags
//   mwre, mhart, rd0a, rd0d     registered regfile write port
module t5_wbck #(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 2,
    parameter int STARVE = 4
) (
    input  logic            sclk,
    input  logic            rstn,
    input  logic            xwre,
    input  logic [1:0]      xhart,
    input  logic [4:0]      xrda,
    input  logic [XLEN-1:0] xrdd,
    output logic            xstall,
    input  logic            lvld,
    output logic            lrdy,
    input  logic [1:0]      lhart,
    input  logic [4:0]      lrda,
    input  logic [XLEN-1:0] lrdd,
    output logic [3:0]      lpend,
    output logic            mwre,
    output logic [1:0]      mhart,
    output logic [4:0]      rd0a,
    output logic [XLEN-1:0] rd0d
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;
    localparam int CW = $clog2(STARVE + 1);
    localparam logic [CW-1:0] STARVE_C  = CW'(STARVE);
    localparam logic [CW-1:0] STARVE_M1 = CW'(STARVE - 1);

    logic [1:0]      f_hart [DEPTH];
    logic [4:0]      f_rda  [DEPTH];
    logic [XLEN-1:0] f_data [DEPTH];

    logic [PW-1:0] wp;
    logic [PW-1:0] rp;
    logic [CW-1:0] wcnt;
    logic          from_fifo;

    logic          empty;
    logic          full;
    logic          push;
    logic          pop;
    logic          take_x;
    logic [PW-1:0] cnt;
    logic [AW-1:0] head;
    logic [CW-1:0] wcnt_nxt;
    logic          stall_nxt;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign lrdy  = ~full;
    assign cnt   = wp - rp;
    assign head  = rp[AW-1:0];

    // Loads to x0 are acknowledged but never occupy a FIFO slot.
    assign push = lvld && !full && (lrda != 5'd0);

    // Port arbitration: a pending stall forces the head out; otherwise execute
    // wins, and a dropped x0 execute result leaves the port to the FIFO.
    always_comb begin
        pop    = 1'b0;
        take_x = 1'b0;
        if (xstall && !empty) begin
            pop = 1'b1;
        end else if (xwre && (xrda != 5'd0) && !xstall) begin
            take_x = 1'b1;
        end else if (!empty) begin
            pop = 1'b1;
        end
    end

    // Wait counter on the current head; the stall fires only on the edge the
    // counter first reaches STARVE, so it is a single-cycle pulse.
    always_comb begin
        wcnt_nxt  = wcnt;
        stall_nxt = 1'b0;
        if (empty || pop) begin
            wcnt_nxt = '0;
        end else if (wcnt != STARVE_C) begin
            wcnt_nxt  = wcnt + 1'b1;
            stall_nxt = (wcnt == STARVE_M1);
        end
    end

    always_ff @(posedge sclk) begin
        if (push) begin
            f_hart[wp[AW-1:0]] <= lhart;
            f_rda[wp[AW-1:0]]  <= lrda;
            f_data[wp[AW-1:0]] <= lrdd;
        end
    end

    always_ff @(posedge sclk or negedge rstn) begin
        if (!rstn) begin
            wp        <= '0;
            rp        <= '0;
            wcnt      <= '0;
            xstall    <= 1'b0;
            mwre      <= 1'b0;
            mhart     <= 2'd0;
            rd0a      <= 5'd0;
            rd0d      <= '0;
            from_fifo <= 1'b0;
        end else begin
            wcnt   <= wcnt_nxt;
            xstall <= stall_nxt;
            if (push) begin
                wp <= wp + 1'b1;
            end
            if (pop) begin
                rp        <= rp + 1'b1;
                mwre      <= 1'b1;
                mhart     <= f_hart[head];
                rd0a      <= f_rda[head];
                rd0d      <= f_data[head];
                from_fifo <= 1'b1;
            end else if (take_x) begin
                mwre      <= 1'b1;
                mhart     <= xhart;
                rd0a      <= xrda;
                rd0d      <= xrdd;
                from_fifo <= 1'b0;
            end else begin
                mwre      <= 1'b0;
                from_fifo <= 1'b0;
            end
        end
    end

    // An entry is live when its distance from the read pointer is below the
    // occupancy; a load stays pending through the cycle it is on the write port.
    always_comb begin
        logic [AW-1:0] off;
        lpend = 4'd0;
        off   = '0;
        for (int i = 0; i < DEPTH; i++) begin
            off = AW'(i) - head;
            if ({1'b0, off} < cnt) begin
                lpend[f_hart[i]] = 1'b1;
            end
        end
        if (mwre && from_fifo) begin
            lpend[mhart] = 1'b1;
        end
    end

endmodule

// File: tb/tb_t5_wbck.sv
// tb/tb_t5_wbck.sv - self-checking bench for t5_wbck against a queue-based reference model
module tb_t5_wbck;

    localparam int XLEN   = 32;
    localparam int DEPTH  = 2;
    localparam int STARVE = 4;

    logic            sclk = 1'b0;
    logic            rstn = 1'b1;
    logic            xwre = 1'b0;
    logic [1:0]      xhart = '0;
    logic [4:0]      xrda = '0;
    logic [XLEN-1:0] xrdd = '0;
    logic            xstall;
    logic            lvld = 1'b0;
    logic            lrdy;
    logic [1:0]      lhart = '0;
    logic [4:0]      lrda = '0;
    logic [XLEN-1:0] lrdd = '0;
    logic [3:0]      lpend;
    logic            mwre;
    logic [1:0]      mhart;
    logic [4:0]      rd0a;
    logic [XLEN-1:0] rd0d;

    t5_wbck #(.XLEN(XLEN), .DEPTH(DEPTH), .STARVE(STARVE)) dut (
        .sclk(sclk), .rstn(rstn),
        .xwre(xwre), .xhart(xhart), .xrda(xrda), .xrdd(xrdd), .xstall(xstall),
        .lvld(lvld), .lrdy(lrdy), .lhart(lhart), .lrda(lrda), .lrdd(lrdd),
        .lpend(lpend),
        .mwre(mwre), .mhart(mhart), .rd0a(rd0a), .rd0d(rd0d)
    );

    always #5 sclk = ~sclk;

    typedef struct packed {
        logic [1:0]      hart;
        logic [4:0]      rda;
        logic [XLEN-1:0] data;
    } ent_t;

    ent_t            q[$];
    int              wait_n;
    logic            e_mwre, e_xstall, e_from;
    logic [1:0]      e_mhart;
    logic [4:0]      e_rd0a;
    logic [XLEN-1:0] e_rd0d;

    int n_vec = 0;
    int n_err = 0;

    task automatic model_reset();
        q.delete();
        wait_n   = 0;
        e_mwre   = 0; e_xstall = 0; e_from = 0;
        e_mhart  = '0; e_rd0a = '0; e_rd0d = '0;
    endtask

    function automatic logic [3:0] exp_lpend();
        logic [3:0] r = 4'd0;
        for (int i = 0; i < q.size(); i++) r[q[i].hart] = 1'b1;
        if (e_mwre && e_from) r[e_mhart] = 1'b1;
        return r;
    endfunction

    // One clock edge of the reference: choose who owns the write port, age the
    // head, then enqueue the accepted load behind whatever was already queued.
    task automatic model_edge();
        bit   ne       = (q.size() != 0);
        bit   acc      = lvld && (q.size() < DEPTH);
        bit   popped   = 0;
        int   old_wait = wait_n;
        ent_t h;
        ent_t n;
        if (e_xstall && ne) popped = 1;
        else if (xwre && xrda != 0 && !e_xstall) begin
            e_mwre = 1; e_from = 0; e_mhart = xhart; e_rd0a = xrda; e_rd0d = xrdd;
        end else if (ne) popped = 1;
        else begin
            e_mwre = 0; e_from = 0;
        end
        if (popped) begin
            h = q.pop_front();
            e_mwre = 1; e_from = 1; e_mhart = h.hart; e_rd0a = h.rda; e_rd0d = h.data;
        end
        if (!ne || popped) wait_n = 0;
        else if (wait_n < STARVE) wait_n = wait_n + 1;
        e_xstall = (wait_n == STARVE) && (old_wait < STARVE);
        if (acc && lrda != 0) begin
            n.hart = lhart; n.rda = lrda; n.data = lrdd;
            q.push_back(n);
        end
    endtask

    task automatic check(input string tag);
        logic [45:0] obs;
        logic [45:0] exp;
        obs = {mwre, mhart, rd0a, rd0d, xstall, lrdy, lpend};
        exp = {e_mwre, e_mhart, e_rd0a, e_rd0d, e_xstall, (q.size() < DEPTH), exp_lpend()};
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_const(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag);
        model_edge();
        @(posedge sclk);
        #1;
        check(tag);
    endtask

    task automatic idle();
        xwre = 0; lvld = 0; xrda = 0; lrda = 0;
    endtask

    initial begin
        int          acc;
        int          stalls;
        bit          took;
        logic [31:0] ldlog[$];
        logic [95:0] lseq;

        model_reset();
        #1 rstn = 1'b0;
        repeat (2) @(posedge sclk);
        #1;
        chk_const("reset_state", {mwre, mhart, rd0a, rd0d, xstall, lrdy, lpend},
                  {1'b0, 2'd0, 5'd0, 32'd0, 1'b0, 1'b1, 4'd0});
        rstn = 1'b1;
        step("idle0");

        // ALU path
        xwre = 1; xhart = 2; xrda = 5; xrdd = 32'hDEADBEEF;
        step("alu");
        chk_const("alu_const", {mwre, mhart, rd0a, rd0d}, {1'b1, 2'd2, 5'd5, 32'hDEADBEEF});
        xrda = 0;
        step("alu_x0");
        chk_const("alu_x0_const", mwre, 1'b0);

        // Load merge with no execute traffic
        idle();
        lvld = 1; lhart = 1; lrda = 7; lrdd = 32'h11;
        step("ld_acc");
        chk_const("ld_acc_const", {mwre, lpend[1]}, {1'b0, 1'b1});
        idle();
        step("ld_wr");
        chk_const("ld_wr_const", {mwre, mhart, rd0a, rd0d, lpend[1]}, {1'b1, 2'd1, 5'd7, 32'h11, 1'b1});
        step("ld_clr");
        chk_const("ld_clr_const", lpend, 4'd0);

        // Backpressure: execute busy every cycle, three loads offered
        acc = 0; stalls = 0;
        for (int c = 0; c < 20; c++) begin
            xwre  = !e_xstall;
            xhart = 2'($urandom);
            xrda  = 5'(1 + $urandom_range(0, 30));
            xrdd  = $urandom & 32'h7FFF_FFFF;
            lvld  = (acc < 3);
            lhart = 2'(acc);
            lrda  = 5'(10 + acc);
            lrdd  = 32'hA000_0001 + acc;
            took  = lvld && (q.size() < DEPTH);
            step("bp");
            if (took) acc++;
            if (xstall) stalls++;
            if (mwre && rd0d[31]) ldlog.push_back(rd0d);
            if (c == 1) chk_const("bp_full", {lrdy, lpend}, {1'b0, 4'b0011});
        end
        chk_const("bp_stalls", stalls, 3);
        chk_const("bp_nloads", ldlog.size(), 3);
        lseq = '0;
        for (int i = 0; i < ldlog.size() && i < 3; i++) lseq[95 - 32*i -: 32] = ldlog[i];
        chk_const("bp_order", lseq, {32'hA000_0001, 32'hA000_0002, 32'hA000_0003});
        idle();
        step("bp_drain");

        // x0 load is swallowed
        lvld = 1; lhart = 3; lrda = 0; lrdd = 32'h5555;
        step("ld_x0");
        chk_const("ld_x0_const", {mwre, lpend, lrdy}, {1'b0, 4'd0, 1'b1});
        idle();
        step("ld_x0_idle");
        chk_const("ld_x0_nowrite", mwre, 1'b0);

        // Back-to-back loads across pointer wrap
        for (int i = 0; i < 10; i++) begin
            lvld = 1; lhart = 2'(i); lrda = 5'(i + 1); lrdd = 32'hC0DE_0000 + i;
            step("wrap");
            chk_const("wrap_lrdy", lrdy, 1'b1);
        end
        idle();
        step("wrap_drain0");
        step("wrap_drain1");

        // Randomised mixed traffic
        for (int c = 0; c < 300; c++) begin
            xwre  = e_xstall ? 1'b0 : 1'($urandom_range(0, 1));
            xhart = 2'($urandom);
            xrda  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
            xrdd  = $urandom;
            lvld  = 1'($urandom_range(0, 1));
            lhart = 2'($urandom);
            lrda  = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            lrdd  = $urandom;
            step("rand");
        end

        // Reset mid-stream with two loads queued
        idle();
        xwre = 1; xrda = 3; xrdd = 32'h1234;
        lvld = 1; lhart = 2; lrda = 9; lrdd = 32'h99;
        step("rst_fill0");
        lhart = 3; lrda = 10; lrdd = 32'hAA;
        step("rst_fill1");
        chk_const("rst_full", {lrdy, lpend}, {1'b0, 4'b1100});
        #2 rstn = 1'b0;
        #1;
        chk_const("rst_async", {mwre, mhart, rd0a, rd0d, xstall, lrdy, lpend},
                  {1'b0, 2'd0, 5'd0, 32'd0, 1'b0, 1'b1, 4'd0});
        idle();
        model_reset();
        @(posedge sclk);
        #1 rstn = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step("rst_after");
            chk_const("rst_nowrite", {mwre, lpend}, {1'b0, 4'd0});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
